// File: rtl/wallace_mult_pipe.sv
// Three-stage pipelined Wallace-tree multiplier, WIDTH x WIDTH -> 2*WIDTH, with
// per-transaction signed (Baugh-Wooley) or unsigned mode and a valid/ready handshake.
module wallace_mult_pipe #(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic               out_signed
);
    localparam int PW = 2 * WIDTH;
    localparam int NR = WIDTH + 1;  // WIDTH partial-product rows plus the correction row

    function automatic int rows_at(input int lvl);
        int n;
        n = NR;
        for (int i = 0; i < lvl; i++) begin
            if (n > 2) n = 2 * (n / 3) + n % 3;
        end
        return n;
    endfunction

    function automatic int num_levels();
        int n;
        int l;
        n = NR;
        l = 0;
        while (n > 2) begin
            n = 2 * (n / 3) + n % 3;
            l++;
        end
        return l;
    endfunction

    localparam int LEVELS = num_levels();
    localparam logic [PW-1:0] CORR = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

    logic adv;
    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

    // S1: AND array; in signed mode exactly the bits pairing one sign bit with
    // one magnitude bit are inverted, and the constant 2^W + 2^(2W-1) is added.
    logic [WIDTH-1:0] pp_bits [0:WIDTH-1];
    logic [PW-1:0]    pp_rows [0:NR-1];

    genvar gi, gj;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_pp_row
            for (gj = 0; gj < WIDTH; gj++) begin : g_pp_bit
                localparam logic INV = ((gi == WIDTH - 1) != (gj == WIDTH - 1));
                assign pp_bits[gi][gj] = (in_a[gj] & in_b[gi]) ^ (in_signed & INV);
            end
            assign pp_rows[gi] = {{WIDTH{1'b0}}, pp_bits[gi]} << gi;
        end
    endgenerate
    assign pp_rows[NR-1] = in_signed ? CORR : '0;

    logic          s1_valid, s1_signed;
    logic [PW-1:0] s1_rows [0:NR-1];
    logic          s2_valid, s2_signed;
    logic [PW-1:0] s2_sum, s2_carry;

    // S2: row-wise Wallace reduction; carries leaving the MSB are dropped since
    // the exact product always fits in 2*WIDTH bits.
    logic [PW-1:0] tree [0:LEVELS][0:NR-1];

    generate
        for (gi = 0; gi < NR; gi++) begin : g_lvl0
            assign tree[0][gi] = s1_rows[gi];
        end
        for (gi = 0; gi < LEVELS; gi++) begin : g_level
            localparam int N = rows_at(gi);
            localparam int G = N / 3;
            localparam int R = N % 3;
            for (gj = 0; gj < G; gj++) begin : g_fa
                assign tree[gi+1][2*gj]   = tree[gi][3*gj] ^ tree[gi][3*gj+1] ^ tree[gi][3*gj+2];
                assign tree[gi+1][2*gj+1] = ((tree[gi][3*gj] & tree[gi][3*gj+1]) |
                                             (tree[gi][3*gj] & tree[gi][3*gj+2]) |
                                             (tree[gi][3*gj+1] & tree[gi][3*gj+2])) << 1;
            end
            if (R == 2) begin : g_ha
                assign tree[gi+1][2*G]   = tree[gi][3*G] ^ tree[gi][3*G+1];
                assign tree[gi+1][2*G+1] = (tree[gi][3*G] & tree[gi][3*G+1]) << 1;
            end else if (R == 1) begin : g_pass
                assign tree[gi+1][2*G] = tree[gi][3*G];
            end
            for (gj = 2 * G + R; gj < NR; gj++) begin : g_idle
                assign tree[gi+1][gj] = '0;
            end
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            out_valid   <= 1'b0;
            out_product <= '0;
            out_signed  <= 1'b0;
        end else if (adv) begin
            s1_valid    <= in_valid;
            s2_valid    <= s1_valid;
            out_valid   <= s2_valid;
            out_product <= s2_sum + s2_carry;
            out_signed  <= s2_signed;
        end
    end

    // Payload of empty stages is don't-care, so these registers carry no reset.
    always_ff @(posedge clock) begin
        if (adv) begin
            s1_signed <= in_signed;
            s1_rows   <= pp_rows;
            s2_signed <= s1_signed;
            s2_sum    <= tree[LEVELS][0];
            s2_carry  <= tree[LEVELS][1];
        end
    end
endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Directed-vector and streaming bench for wallace_mult_pipe at WIDTH=8: latency,
// signed/unsigned corners, random streaming, backpressure and mid-stream reset.
module tb_wallace_mult_pipe;
    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_signed;
    logic [7:0]  in_a, in_b;
    logic        out_valid, out_ready, out_signed;
    logic [15:0] out_product;

    wallace_mult_pipe #(.WIDTH(8)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .out_signed(out_signed)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] p;
    } vec_t;

    typedef struct {
        logic [15:0] p;
        logic        s;
    } exp_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   pop_cnt, first_pop, last_pop;
    bit   mon_en = 1'b0;
    exp_t exp_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic logic [15:0] gold(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic signed [15:0] sa, sb;
        if (s) begin
            sa = {{8{a[7]}}, a};
            sb = {{8{b[7]}}, b};
            return 16'(sa * sb);
        end
        return {8'h00, a} * {8'h00, b};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard: observe transfers mid-cycle, ahead of the edge that commits them.
    always @(negedge clock) begin
        if (mon_en) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'(out_product), 32'hDEAD);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("stream_product", 32'(out_product), 32'(e.p));
                    check("stream_signed", 32'(out_signed), 32'(e.s));
                    if (pop_cnt == 0) first_pop = cyc;
                    last_pop = cyc;
                    pop_cnt++;
                end
            end
            if (in_valid && in_ready) exp_q.push_back('{p: gold(in_a, in_b, in_signed), s: in_signed});
        end
    end

    task automatic run_one(input vec_t v, input int idx);
        int lat;
        in_a = v.a; in_b = v.b; in_signed = v.s; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            step();
            lat++;
        end
        check($sformatf("v%0d_latency", idx), 32'(lat), 32'd3);
        check($sformatf("v%0d_product", idx), 32'(out_product), 32'(v.p));
        check($sformatf("v%0d_signed", idx), 32'(out_signed), 32'(v.s));
        $display("vec %0d: %s 0x%02h * 0x%02h -> 0x%04h", idx, v.s ? "s" : "u", v.a, v.b, out_product);
        step();
    endtask

    task automatic drain(input string nm);
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 20) begin
            step();
            w++;
        end
        check(nm, 32'(exp_q.size()), 32'd0);
    endtask

    vec_t vecs [13];
    logic [7:0] sweep_b [3];

    initial begin
        int stall_cycles, held_prev, idx, stale;
        logic [15:0] held_val;
        logic [7:0]  bp_a [8];
        logic [7:0]  bp_b [8];

        vecs[0]  = '{a: 8'hFF, b: 8'hFF, s: 1'b0, p: 16'hFE01};
        vecs[1]  = '{a: 8'hFF, b: 8'hFF, s: 1'b1, p: 16'h0001};
        vecs[2]  = '{a: 8'h80, b: 8'h80, s: 1'b1, p: 16'h4000};
        vecs[3]  = '{a: 8'h80, b: 8'h7F, s: 1'b1, p: 16'hC080};
        vecs[4]  = '{a: 8'h80, b: 8'h80, s: 1'b0, p: 16'h4000};
        vecs[5]  = '{a: 8'h7F, b: 8'h7F, s: 1'b1, p: 16'h3F01};
        vecs[6]  = '{a: 8'h00, b: 8'hFF, s: 1'b0, p: 16'h0000};
        vecs[7]  = '{a: 8'h01, b: 8'hFF, s: 1'b1, p: 16'hFFFF};
        vecs[8]  = '{a: 8'hFF, b: 8'h01, s: 1'b0, p: 16'h00FF};
        vecs[9]  = '{a: 8'h03, b: 8'h05, s: 1'b1, p: 16'h000F};
        vecs[10] = '{a: 8'hFE, b: 8'h03, s: 1'b1, p: 16'hFFFA};
        vecs[11] = '{a: 8'h12, b: 8'h34, s: 1'b0, p: 16'h03A8};
        vecs[12] = '{a: 8'h80, b: 8'h01, s: 1'b1, p: 16'hFF80};
        sweep_b[0] = 8'h80; sweep_b[1] = 8'h7F; sweep_b[2] = 8'hFF;

        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_product", 32'(out_product), 32'd0);
        check("reset_out_signed", 32'(out_signed), 32'd0);
        reset = 1'b0;
        step();
        check("idle_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 13; i++) run_one(vecs[i], i);

        // Random mixed-mode stream, one operand pair every cycle.
        mon_en = 1'b1; pop_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            in_a = 8'($urandom); in_b = 8'($urandom); in_signed = 1'($urandom); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        drain("stream_drained");
        check("stream_count", 32'(pop_cnt), 32'd256);
        check("stream_no_gaps", 32'(last_pop - first_pop), 32'd255);
        $display("stream: %0d products, span %0d cycles", pop_cnt, last_pop - first_pop + 1);

        // Boundary sweep: every a against the extreme b values, both modes.
        pop_cnt = 0;
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < 3; k++)
                for (int a = 0; a < 256; a++) begin
                    in_a = 8'(a); in_b = sweep_b[k]; in_signed = 1'(s); in_valid = 1'b1;
                    step();
                end
        in_valid = 1'b0;
        drain("sweep_drained");
        check("sweep_count", 32'(pop_cnt), 32'd1536);
        $display("sweep: %0d products", pop_cnt);

        // Backpressure: consumer stalls for 5 cycles with the pipe full.
        pop_cnt = 0; idx = 0; stall_cycles = 0; held_prev = 0; held_val = '0;
        for (int i = 0; i < 8; i++) begin
            bp_a[i] = 8'($urandom); bp_b[i] = 8'($urandom);
        end
        for (int c = 0; c < 30; c++) begin
            out_ready = !(c >= 4 && c < 9);
            in_valid  = (idx < 8);
            in_a      = bp_a[idx % 8];
            in_b      = bp_b[idx % 8];
            in_signed = 1'(idx % 2);
            @(negedge clock);
            if (out_valid && !out_ready) begin
                stall_cycles++;
                check("bp_in_ready", 32'(in_ready), 32'd0);
                if (held_prev != 0) check("bp_held_product", 32'(out_product), 32'(held_val));
                held_prev = 1;
                held_val  = out_product;
            end else begin
                held_prev = 0;
            end
            if (in_valid && in_ready) idx++;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        drain("bp_drained");
        check("bp_stall_cycles", 32'(stall_cycles), 32'd5);
        check("bp_count", 32'(pop_cnt), 32'd8);
        $display("backpressure: %0d stall cycles, %0d products", stall_cycles, pop_cnt);

        // Reset with three operations in flight.
        mon_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_a = 8'h11 + 8'(i); in_b = 8'h22; in_signed = 1'b0; in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        check("pre_reset_out_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("async_reset_out_valid", 32'(out_valid), 32'd0);
        check("async_reset_out_product", 32'(out_product), 32'd0);
        step();
        reset = 1'b0;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid) stale++;
        end
        check("no_stale_after_reset", 32'(stale), 32'd0);
        $display("reset: %0d stale outputs after release", stale);
        exp_q.delete();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
